sr_config_loader: RTL

- Serial writer for the PS-PWM core's 18-bit configuration shift register; drives the CLK_SR / Data_SR pins from a parallel configuration word.
- Sits in the FPGA-side test controller or the on-chip bring-up logic, on the other end of the configuration shift-register link.
- Bit order on the link is LSB first. Word bit 0 = dt[0], bit 17 = ENABLE_OUTPUT, which matches the core's field order.
- Generates a glitch-free, fully registered serial clock with programmable half-period, plus busy/done status.

---
 rtl/sr_config_loader_if.sv | 31 +++
 rtl/sr_config_loader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sr_config_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_config_loader_if : request/status and serial-pin bundle of sr_config_loader
// Rev 1.0
// ---------------------------------------------------------------------------
interface sr_config_loader_if #(
  parameter int N_BITS = 18,
  parameter int DIV_W  = 8,
  parameter int CNT_W  = 5
);
  logic              start;
  logic              abort;
  logic [N_BITS-1:0] cfg_word;
  logic [DIV_W-1:0]  half_period;
  logic              sr_clk;
  logic              sr_data;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bit_idx;

  modport master (
    output start, abort, cfg_word, half_period,
    input  sr_clk, sr_data, busy, done, bit_idx
  );

  modport slave (
    input  start, abort, cfg_word, half_period,
    output sr_clk, sr_data, busy, done, bit_idx
  );
endinterface
`default_nettype wire

// File: rtl/sr_config_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_config_loader : LSB-first serial writer for the 18-bit PS-PWM config
//                    shift register, registered sr_clk with programmable H.
// Rev 1.0
// ---------------------------------------------------------------------------
module sr_config_loader #(
  parameter int N_BITS = 18,
  parameter int DIV_W  = 8,
  parameter int CNT_W  = 5
) (
  input  wire logic         clk,
  input  wire logic         RST,
  sr_config_loader_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(N_BITS - 1);
  localparam logic [DIV_W-1:0] c_one      = DIV_W'(1);

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_h, w_h_nxt;
  logic [DIV_W-1:0]  r_cnt, w_cnt_nxt;
  logic [N_BITS-1:0] r_shift, w_shift_nxt, w_shift_dn;
  logic [CNT_W-1:0]  r_bit_idx, w_bit_idx_nxt;
  logic              r_sr_clk, w_sr_clk_nxt;
  logic              r_sr_data, w_sr_data_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [DIV_W-1:0]  w_h_in;
  logic              w_phase_end;

  assign w_h_in      = (bus.half_period == '0) ? c_one : bus.half_period;
  assign w_phase_end = (r_cnt == '0);
  assign w_shift_dn  = r_shift >> 1;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_h       <= c_one;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_sr_clk  <= 1'b0;
      r_sr_data <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_h       <= w_h_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_sr_clk  <= w_sr_clk_nxt;
      r_sr_data <= w_sr_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_h_nxt       = r_h;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_sr_clk_nxt  = r_sr_clk;
    w_sr_data_nxt = r_sr_data;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    if (bus.abort) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = '0;
      w_bit_idx_nxt = '0;
      w_sr_clk_nxt  = 1'b0;
      w_sr_data_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // r_done blocks a start landing on the completion cycle
          if (bus.start && !r_done) begin
            w_h_nxt       = w_h_in;
            w_cnt_nxt     = w_h_in - c_one;
            w_shift_nxt   = bus.cfg_word;
            w_bit_idx_nxt = '0;
            w_sr_data_nxt = bus.cfg_word[0];
            w_busy_nxt    = 1'b1;
            w_state_nxt   = S_LOW;
          end
        end
        S_LOW: begin
          if (w_phase_end) begin
            w_cnt_nxt    = r_h - c_one;
            w_sr_clk_nxt = 1'b1;
            w_state_nxt  = S_HIGH;
          end else begin
            w_cnt_nxt = r_cnt - c_one;
          end
        end
        S_HIGH: begin
          if (w_phase_end) begin
            w_cnt_nxt    = r_h - c_one;
            w_sr_clk_nxt = 1'b0;
            if (r_bit_idx != c_last_idx) begin
              w_shift_nxt   = w_shift_dn;
              w_sr_data_nxt = w_shift_dn[0];
              w_bit_idx_nxt = r_bit_idx + 1'b1;
              w_state_nxt   = S_LOW;
            end else begin
              w_sr_data_nxt = 1'b0;
              w_state_nxt   = S_TAIL;
            end
          end else begin
            w_cnt_nxt = r_cnt - c_one;
          end
        end
        S_TAIL: begin
          if (w_phase_end) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - c_one;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.sr_clk  = r_sr_clk;
  assign bus.sr_data = r_sr_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bit_idx = r_bit_idx;
endmodule
`default_nettype wire
